wb_port_sequencer: RTL and testbench

Serialises the two write-back requests of one Y86-64 instruction (E-port result valE to dstE, M-port result valM to dstM) onto a register file with a single write port. Sits between the write-back destination selection logic and the register file. Stalls the upstream stage for one cycle when an instruction needs two distinct register writes. Enforces M-over-E priority when both target the same register (popq %rsp).

---
 rtl/y86_pkg.sv | 23 ++
 rtl/wb_req_classify.sv | 30 +++
 rtl/wb_port_sequencer.sv | 121 ++++++++++++
 tb/tb_wb_port_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared constants and types for the Y86-64 write-back path.
// Holds register IDs, datapath widths, the sequencer state encoding and request classes.
package y86_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE     = 2'd0,
        REQ_SINGLE_E = 2'd1,
        REQ_SINGLE_M = 2'd2,
        REQ_DUAL     = 2'd3
    } req_class_t;

endpackage

// File: rtl/wb_req_classify.sv
// Decodes a write-back request into NONE / SINGLE_E / SINGLE_M / DUAL.
// A shared destination collapses to SINGLE_M so the M result wins (popq %rsp).
module wb_req_classify #(
    parameter int                ADDR_W = y86_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RNONE  = y86_pkg::RNONE
) (
    input  logic [ADDR_W-1:0]   dstE,
    input  logic [ADDR_W-1:0]   dstM,
    output y86_pkg::req_class_t req_class
);
    import y86_pkg::*;

    logic e_wr;
    logic m_wr;

    assign e_wr = (dstE != RNONE);
    assign m_wr = (dstM != RNONE);

    always_comb begin
        req_class = REQ_NONE;
        if (e_wr && m_wr) begin
            req_class = (dstE == dstM) ? REQ_SINGLE_M : REQ_DUAL;
        end else if (m_wr) begin
            req_class = REQ_SINGLE_M;
        end else if (e_wr) begin
            req_class = REQ_SINGLE_E;
        end
    end

endmodule

// File: rtl/wb_port_sequencer.sv
// Serialises the E and M write-back results onto a single-write-port register file.
// A DUAL request issues E first, parks M in pend_* for one cycle, and stalls upstream.
//
// state | meaning
// IDLE  | ready for a request; issues its first (or only) write
// HOLD  | issuing the parked M write; upstream stalled
module wb_port_sequencer #(
    parameter int                DATA_W = y86_pkg::DATA_W,
    parameter int                ADDR_W = y86_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RNONE  = y86_pkg::RNONE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_dst,
    output logic [DATA_W-1:0] pend_val,
    output logic [31:0]       wr_count
);
    import y86_pkg::*;

    state_t            state;
    state_t            state_nx;
    req_class_t        req_class;
    logic              rf_we_nx;
    logic [ADDR_W-1:0] rf_addr_nx;
    logic [DATA_W-1:0] rf_data_nx;
    logic              pend_valid_nx;
    logic [ADDR_W-1:0] pend_dst_nx;
    logic [DATA_W-1:0] pend_val_nx;

    wb_req_classify #(
        .ADDR_W (ADDR_W),
        .RNONE  (RNONE)
    ) u_classify (
        .dstE      (dstE),
        .dstM      (dstM),
        .req_class (req_class)
    );

    assign in_ready = (state == IDLE);

    always_comb begin
        state_nx      = state;
        rf_we_nx      = 1'b0;
        rf_addr_nx    = rf_addr;
        rf_data_nx    = rf_data;
        pend_valid_nx = pend_valid;
        pend_dst_nx   = pend_dst;
        pend_val_nx   = pend_val;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    case (req_class)
                        REQ_SINGLE_E: begin
                            rf_we_nx   = 1'b1;
                            rf_addr_nx = dstE;
                            rf_data_nx = valE;
                        end
                        REQ_SINGLE_M: begin
                            rf_we_nx   = 1'b1;
                            rf_addr_nx = dstM;
                            rf_data_nx = valM;
                        end
                        REQ_DUAL: begin
                            rf_we_nx      = 1'b1;
                            rf_addr_nx    = dstE;
                            rf_data_nx    = valE;
                            pend_valid_nx = 1'b1;
                            pend_dst_nx   = dstM;
                            pend_val_nx   = valM;
                            state_nx      = HOLD;
                        end
                        default: ;
                    endcase
                end
            end
            HOLD: begin
                // pend_val is left as-is; it is only meaningful with pend_valid.
                rf_we_nx      = 1'b1;
                rf_addr_nx    = pend_dst;
                rf_data_nx    = pend_val;
                pend_valid_nx = 1'b0;
                pend_dst_nx   = RNONE;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rf_we      <= 1'b0;
            rf_addr    <= RNONE;
            rf_data    <= '0;
            pend_valid <= 1'b0;
            pend_dst   <= RNONE;
            pend_val   <= '0;
            wr_count   <= '0;
        end else begin
            state      <= state_nx;
            rf_we      <= rf_we_nx;
            rf_addr    <= rf_addr_nx;
            rf_data    <= rf_data_nx;
            pend_valid <= pend_valid_nx;
            pend_dst   <= pend_dst_nx;
            pend_val   <= pend_val_nx;
            wr_count   <= wr_count + 32'(rf_we_nx);
        end
    end

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Directed bench for wb_port_sequencer: a queue-of-writes reference model checked every
// cycle, plus hand-computed literal expectations at key points of the sequence.
module tb_wb_port_sequencer;

    localparam logic [3:0] RN = 4'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  dstE = RN;
    logic [63:0] valE = '0;
    logic [3:0]  dstM = RN;
    logic [63:0] valM = '0;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [63:0] rf_data;
    logic        pend_valid;
    logic [3:0]  pend_dst;
    logic [63:0] pend_val;
    logic [31:0] wr_count;

    int checks = 0;
    int errors = 0;

    wb_port_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dstE       (dstE),
        .valE       (valE),
        .dstM       (dstM),
        .valM       (valM),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .pend_valid (pend_valid),
        .pend_dst   (pend_dst),
        .pend_val   (pend_val),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  a;
        logic [63:0] d;
    } wr_t;

    // Reference model: writes still owed to the register file, in issue order.
    wr_t         owed[$];
    wr_t         req_w[$];
    logic        m_we   = 1'b0;
    logic [3:0]  m_addr = RN;
    logic [63:0] m_data = '0;
    logic [31:0] m_cnt  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input wr_t w);
        m_we   = 1'b1;
        m_addr = w.a;
        m_data = w.d;
        m_cnt  = m_cnt + 32'd1;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                owed.delete();
                m_we   = 1'b0;
                m_addr = RN;
                m_data = '0;
                m_cnt  = '0;
            end else if (owed.size() != 0) begin
                issue(owed.pop_front());
            end else if (in_valid) begin
                req_w.delete();
                if (dstE != RN && dstE != dstM) req_w.push_back({dstE, valE});
                if (dstM != RN) req_w.push_back({dstM, valM});
                if (req_w.size() == 0) m_we = 1'b0;
                else begin
                    issue(req_w.pop_front());
                    while (req_w.size() != 0) owed.push_back(req_w.pop_front());
                end
            end else begin
                m_we = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("cyc_in_ready", 64'(in_ready), 64'(owed.size() == 0));
                chk("cyc_rf_we", 64'(rf_we), 64'(m_we));
                chk("cyc_rf_addr", 64'(rf_addr), 64'(m_addr));
                chk("cyc_rf_data", rf_data, m_data);
                chk("cyc_wr_count", 64'(wr_count), 64'(m_cnt));
                chk("cyc_pend_valid", 64'(pend_valid), 64'(owed.size() != 0));
                chk("cyc_pend_dst", 64'(pend_dst), 64'(owed.size() != 0 ? owed[0].a : RN));
                if (owed.size() != 0) chk("cyc_pend_val", pend_val, owed[0].d);
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        in_valid = v;
        dstE = de;
        valE = ve;
        dstM = dm;
        valM = vm;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic we, input logic [3:0] a,
                              input logic [63:0] d, input logic rdy, input logic pv,
                              input logic [31:0] cnt);
        chk({tag, "_we"}, 64'(rf_we), 64'(we));
        if (we) begin
            chk({tag, "_addr"}, 64'(rf_addr), 64'(a));
            chk({tag, "_data"}, rf_data, d);
        end
        chk({tag, "_ready"}, 64'(in_ready), 64'(rdy));
        chk({tag, "_pend_valid"}, 64'(pend_valid), 64'(pv));
        chk({tag, "_count"}, 64'(wr_count), 64'(cnt));
    endtask

    typedef struct {
        logic [3:0]  de;
        logic [63:0] ve;
        logic [3:0]  dm;
        logic [63:0] vm;
    } vec_t;

    vec_t mix[6];

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_addr", 64'(rf_addr), 64'hF);
        chk("rst_data", rf_data, 64'd0);
        chk("rst_pend_dst", 64'(pend_dst), 64'hF);
        expect_out("rst", 1'b0, RN, '0, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // in_valid low with a real destination must not write
        drive(1'b0, 4'd3, 64'h9, RN, 64'h0);
        expect_out("no_valid", 1'b0, RN, '0, 1'b1, 1'b0, 32'd0);

        drive(1'b1, 4'd3, 64'h5, RN, 64'h0);
        expect_out("single_e", 1'b1, 4'd3, 64'h5, 1'b1, 1'b0, 32'd1);

        drive(1'b1, 4'd4, 64'h100, 4'd4, 64'hABC);
        expect_out("popq_rsp", 1'b1, 4'd4, 64'hABC, 1'b1, 1'b0, 32'd2);

        drive(1'b1, 4'd4, 64'h108, 4'd3, 64'h77);
        expect_out("dual_c1", 1'b1, 4'd4, 64'h108, 1'b0, 1'b1, 32'd3);
        chk("dual_c1_pend_dst", 64'(pend_dst), 64'd3);
        chk("dual_c1_pend_val", pend_val, 64'h77);
        drive(1'b0, RN, 64'h0, RN, 64'h0);
        expect_out("dual_c2", 1'b1, 4'd3, 64'h77, 1'b1, 1'b0, 32'd4);
        chk("dual_c2_pend_dst", 64'(pend_dst), 64'hF);

        // back-to-back: SINGLE_E held through the stall
        drive(1'b1, 4'd5, 64'h11, 4'd6, 64'h22);
        expect_out("b2b_e", 1'b1, 4'd5, 64'h11, 1'b0, 1'b1, 32'd5);
        drive(1'b1, 4'd2, 64'h33, RN, 64'h0);
        expect_out("b2b_m", 1'b1, 4'd6, 64'h22, 1'b1, 1'b0, 32'd6);
        drive(1'b1, 4'd2, 64'h33, RN, 64'h0);
        expect_out("b2b_next", 1'b1, 4'd2, 64'h33, 1'b1, 1'b0, 32'd7);
        drive(1'b0, RN, 64'h0, RN, 64'h0);
        expect_out("b2b_idle", 1'b0, RN, '0, 1'b1, 1'b0, 32'd7);
        chk("hold_addr", 64'(rf_addr), 64'd2);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, RN, 64'h1, RN, 64'h2);
            expect_out("none", 1'b0, RN, '0, 1'b1, 1'b0, 32'd7);
        end

        drive(1'b1, 4'd1, 64'hAA, 4'd7, 64'hBB);
        expect_out("rsthold_c1", 1'b1, 4'd1, 64'hAA, 1'b0, 1'b1, 32'd8);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 1'b0, RN, '0, 1'b1, 1'b0, 32'd0);
        chk("async_rst_addr", 64'(rf_addr), 64'hF);
        chk("async_rst_pend_dst", 64'(pend_dst), 64'hF);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, RN, 64'h0, RN, 64'h0);
        expect_out("post_rst", 1'b0, RN, '0, 1'b1, 1'b0, 32'd0);
        drive(1'b1, RN, 64'h0, 4'd9, 64'hDEAD);
        expect_out("single_m", 1'b1, 4'd9, 64'hDEAD, 1'b1, 1'b0, 32'd1);

        // mixed run checked by the model
        mix[0] = '{4'd0, 64'h1000, 4'd14, 64'h2000};
        mix[1] = '{4'd14, 64'h3, RN, 64'h0};
        mix[2] = '{RN, 64'h0, RN, 64'h0};
        mix[3] = '{4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 64'h1234};
        mix[4] = '{4'd10, 64'h5555, 4'd11, 64'hAAAA};
        mix[5] = '{4'd12, 64'h42, RN, 64'h0};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, mix[i].de, mix[i].ve, mix[i].dm, mix[i].vm);
            while (!in_ready) drive(1'b1, mix[i].de, mix[i].ve, mix[i].dm, mix[i].vm);
        end
        drive(1'b0, RN, 64'h0, RN, 64'h0);
        chk("mix_count", 64'(wr_count), 64'd8);
        drive(1'b0, RN, 64'h0, RN, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
